pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of the datapath payload (PC, ALU result, store data, register index packed by the instantiating stage).
REQ-002 Parameter CTRL_W, default 8, width of the control-bit bundle (regwrite, memwrite, memread, memtoreg, branch, zero, ...).
REQ-003 Parameter STAGES, default 1, legal 1..4, number of cascaded register stages.
REQ-004 Parameter CTRL_CLR_MASK, default all ones (CTRL_W bits), control bits forced to 0 on flush; bits at 0 hold their value on flush.
REQ-005 Parameter CNT_W, default 16, width of the performance counters.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst_n  input  1  synchronous active-low reset.
REQ-008 in_valid  input  1  upstream entry is a real instruction.
REQ-009 in_ctrl  input  CTRL_W  upstream control bundle.
REQ-010 in_data  input  DATA_W  upstream payload.
REQ-011 stall  input  1  hold all stages this cycle.
REQ-012 flush  input  1  convert all stages to bubbles this cycle.
REQ-013 out_valid  output  1  last-stage valid.
REQ-014 out_ctrl  output  CTRL_W  last-stage control bundle.
REQ-015 out_data  output  DATA_W  last-stage payload.
REQ-016 stall_cnt  output  CNT_W  count of cycles with stall accepted.
REQ-017 flush_cnt  output  CNT_W  count of cycles with flush accepted.

Function
REQ-018 Priority per rising edge SHALL be: reset > flush > stall > load.
REQ-019 Load (no flush, no stall): stage 0 SHALL capture in_valid/in_ctrl/in_data; stage k SHALL capture stage k-1.
REQ-020 Latency in_* to out_* SHALL be exactly STAGES cycles with no stalls or flushes.
REQ-021 Stall: every stage SHALL hold valid, ctrl and data unchanged; inputs SHALL be ignored.
REQ-022 Flush: every stage SHALL set valid to 0 and clear ctrl bits selected by CTRL_CLR_MASK; unmasked ctrl bits and data SHALL hold.
REQ-023 Flush and stall asserted together: flush SHALL take effect; stall SHALL NOT be counted.
REQ-024 A stage with valid 0 SHALL still propagate its ctrl/data on load; consumers qualify on out_valid.
REQ-025 Outputs SHALL be driven directly from last-stage flops, no combinational path from any input.
REQ-026 Flush on the cycle immediately after reset release SHALL leave all state at reset values.

Reset
REQ-027 With rst_n low at a rising edge, every stage valid, ctrl and data SHALL be 0, and stall_cnt and flush_cnt SHALL be 0.
REQ-028 Reset asserted mid-stall or mid-flush SHALL override both with no residual effect on the following cycle.
REQ-029 Reset SHALL have no effect between clock edges.

Configuration
REQ-030 Macro PIPE_STAGE_REG_PERF_EN defined: stall_cnt SHALL increment on each edge where stall is accepted (REQ-023), and flush_cnt SHALL increment on each edge with flush; both SHALL saturate at all ones and never wrap.
REQ-031 Macro PIPE_STAGE_REG_PERF_EN undefined: the counters SHALL NOT be synthesised; stall_cnt and flush_cnt SHALL be constant 0; all other behaviour SHALL be identical.

Verification
REQ-032 Load: STAGES=2, in_valid=1, in_ctrl=8'hA5, in_data=32'h0000_1234 at cycle 0 -> out_valid=1, out_ctrl=8'hA5, out_data=32'h0000_1234 after the cycle-1 edge and not before.
REQ-033 Stall: out_data=32'h10 with stall high 3 cycles while in_data=32'h20 -> out_data stays 32'h10 for 3 cycles; stall_cnt=3 (PERF_EN).
REQ-034 Flush mask: CTRL_CLR_MASK=8'h0F, stage ctrl=8'hFF, data=32'hDEAD_BEEF, flush 1 cycle -> out_valid=0, out_ctrl=8'hF0, out_data=32'hDEAD_BEEF.
REQ-035 Flush+stall together for 1 cycle -> flush behaviour of REQ-022 applies; flush_cnt=1, stall_cnt=0.
REQ-036 Reset mid-operation: pipeline full (valid=1 in all stages), rst_n low 1 edge with stall high -> all outputs 0, counters 0.
REQ-037 Saturation: CNT_W=4, stall held 20 cycles with PERF_EN -> stall_cnt=4'hF and holds; without PERF_EN -> stall_cnt=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: STAGES-deep pipeline register with stall/flush and bubble tracking.
// Define PIPE_STAGE_REG_PERF_EN to build saturating stall/flush event counters.
module pipe_stage_reg #(
  parameter int                DATA_W        = 32,
  parameter int                CTRL_W        = 8,
  parameter int                STAGES        = 1,
  parameter logic [CTRL_W-1:0] CTRL_CLR_MASK = {CTRL_W{1'b1}},
  parameter int                CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic              valid_r     [STAGES];
  logic [CTRL_W-1:0] ctrl_r      [STAGES];
  logic [DATA_W-1:0] data_r      [STAGES];

  logic              src_valid_s [STAGES];
  logic [CTRL_W-1:0] src_ctrl_s  [STAGES];
  logic [DATA_W-1:0] src_data_s  [STAGES];

  logic              valid_s     [STAGES];
  logic [CTRL_W-1:0] ctrl_s      [STAGES];
  logic [DATA_W-1:0] data_s      [STAGES];

  // Stage 0 loads from the upstream inputs, stage k from stage k-1.
  assign src_valid_s[0] = in_valid;
  assign src_ctrl_s[0]  = in_ctrl;
  assign src_data_s[0]  = in_data;

  for (genvar g = 1; g < STAGES; g++) begin : g_chain
    assign src_valid_s[g] = valid_r[g-1];
    assign src_ctrl_s[g]  = ctrl_r[g-1];
    assign src_data_s[g]  = data_r[g-1];
  end

  // Next-state per stage: flush beats stall beats load. Bubbles still carry ctrl/data.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      valid_s[k] = valid_r[k];
      ctrl_s[k]  = ctrl_r[k];
      data_s[k]  = data_r[k];
      if (flush) begin
        valid_s[k] = 1'b0;
        ctrl_s[k]  = ctrl_r[k] & ~CTRL_CLR_MASK;
        data_s[k]  = data_r[k];
      end else if (stall) begin
        valid_s[k] = valid_r[k];
        ctrl_s[k]  = ctrl_r[k];
        data_s[k]  = data_r[k];
      end else begin
        valid_s[k] = src_valid_s[k];
        ctrl_s[k]  = src_ctrl_s[k];
        data_s[k]  = src_data_s[k];
      end
    end
  end

  // Stage flops with synchronous active-low reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES; k++) begin
      if (!rst_n) begin
        valid_r[k] <= 1'b0;
        ctrl_r[k]  <= {CTRL_W{1'b0}};
        data_r[k]  <= {DATA_W{1'b0}};
      end else begin
        valid_r[k] <= valid_s[k];
        ctrl_r[k]  <= ctrl_s[k];
        data_r[k]  <= data_s[k];
      end
    end
  end

  assign out_valid = valid_r[STAGES-1];
  assign out_ctrl  = ctrl_r[STAGES-1];
  assign out_data  = data_r[STAGES-1];

`ifdef PIPE_STAGE_REG_PERF_EN
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;
  logic             stall_acc_s;

  // Counters stick at all ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // A stall that coincides with a flush is not accepted and is not counted.
  assign stall_acc_s = stall & ~flush;

  // Performance counters, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_r <= stall_acc_s ? sat_inc(stall_cnt_r) : stall_cnt_r;
      flush_cnt_r <= flush ? sat_inc(flush_cnt_r) : flush_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`else
  assign stall_cnt = {CNT_W{1'b0}};
  assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg (STAGES=2, CTRL_CLR_MASK=8'h0F, CNT_W=4)
// against a stage-array reference model built from the stall/flush/load rules.
module tb_pipe_stage_reg;
  localparam int          ST   = 2;
  localparam int          CW   = 8;
  localparam int          DW   = 32;
  localparam int          NW   = 4;
  localparam logic [7:0]  MASK = 8'h0F;
  localparam int          CMAX = 15;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          stall;
  logic          flush;
  logic          out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [NW-1:0] stall_cnt;
  logic [NW-1:0] flush_cnt;

  pipe_stage_reg #(
    .DATA_W(DW), .CTRL_W(CW), .STAGES(ST), .CTRL_CLR_MASK(MASK), .CNT_W(NW)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ctrl(in_ctrl),
    .in_data(in_data), .stall(stall), .flush(flush), .out_valid(out_valid),
    .out_ctrl(out_ctrl), .out_data(out_data), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic          m_valid [ST];
  logic [CW-1:0] m_ctrl  [ST];
  logic [DW-1:0] m_data  [ST];
  int            m_scnt;
  int            m_fcnt;

  task automatic model_edge();
    if (!rst_n) begin
      for (int k = 0; k < ST; k++) begin
        m_valid[k] = 1'b0; m_ctrl[k] = '0; m_data[k] = '0;
      end
      m_scnt = 0; m_fcnt = 0;
    end else if (flush) begin
      for (int k = 0; k < ST; k++) begin
        m_valid[k] = 1'b0;
        m_ctrl[k]  = m_ctrl[k] & ~MASK;
      end
      m_fcnt = (m_fcnt < CMAX) ? m_fcnt + 1 : CMAX;
    end else if (stall) begin
      m_scnt = (m_scnt < CMAX) ? m_scnt + 1 : CMAX;
    end else begin
      for (int k = ST - 1; k > 0; k--) begin
        m_valid[k] = m_valid[k-1]; m_ctrl[k] = m_ctrl[k-1]; m_data[k] = m_data[k-1];
      end
      m_valid[0] = in_valid; m_ctrl[0] = in_ctrl; m_data[0] = in_data;
    end
  endtask

  function automatic logic [40:0] exp_out();
    return {m_valid[ST-1], m_ctrl[ST-1], m_data[ST-1]};
  endfunction

  function automatic logic [3:0] perf(input int v);
`ifdef PIPE_STAGE_REG_PERF_EN
    logic [3:0] r;
    r = v[3:0];
    return r;
`else
    return 4'h0;
`endif
  endfunction

  // One rising edge, model updated with the inputs it sampled; returns at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic rand_in();
    in_valid = 1'($urandom);
    in_ctrl  = 8'($urandom);
    in_data  = $urandom;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; rand_in();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b1; flush = 1'b1; rand_in();
    tick(); tick();
    n_tests++;
    if ({out_valid, out_ctrl, out_data} !== 41'h0) begin
      n_fail++; $display("FAIL reset_out: got %h expected 0", {out_valid, out_ctrl, out_data});
    end
    n_tests++;
    if ({stall_cnt, flush_cnt} !== 8'h00) begin
      n_fail++; $display("FAIL reset_cnt: got %h expected 00", {stall_cnt, flush_cnt});
    end
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_load();
    do_reset();
    in_valid = 1'b1; in_ctrl = 8'hA5; in_data = 32'h0000_1234;
    tick();
    rand_in();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL load_early: out_valid got %b expected 0", out_valid);
    end
    tick();
    n_tests++;
    if ({out_valid, out_ctrl, out_data} !== {1'b1, 8'hA5, 32'h0000_1234}) begin
      n_fail++; $display("FAIL load_out: got %h expected %h",
                         {out_valid, out_ctrl, out_data}, {1'b1, 8'hA5, 32'h0000_1234});
    end
  endtask

  task automatic test_stall();
    do_reset();
    in_valid = 1'b1; in_ctrl = 8'h3C; in_data = 32'h10;
    tick();
    in_data = 32'h20;
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (out_data !== 32'h10) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got %h expected 00000010", i, out_data);
      end
    end
    n_tests++;
    if (stall_cnt !== perf(3)) begin
      n_fail++; $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt, perf(3));
    end
    stall = 1'b0; in_data = 32'h30;
    tick();
    n_tests++;
    if (out_data !== 32'h20) begin
      n_fail++; $display("FAIL stall_release: got %h expected 00000020", out_data);
    end
  endtask

  task automatic test_flush_mask();
    do_reset();
    in_valid = 1'b1; in_ctrl = 8'hFF; in_data = 32'hDEAD_BEEF;
    tick(); tick();
    flush = 1'b1; rand_in();
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_tests++;
    if ({out_valid, out_ctrl, out_data} !== {1'b0, 8'hF0, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL flush_mask: got %h expected %h",
                         {out_valid, out_ctrl, out_data}, {1'b0, 8'hF0, 32'hDEAD_BEEF});
    end
    n_tests++;
    if (flush_cnt !== perf(1)) begin
      n_fail++; $display("FAIL flush_cnt: got %0d expected %0d", flush_cnt, perf(1));
    end
    tick();
    n_tests++;
    if ({out_valid, out_ctrl, out_data} !== {1'b0, 8'hF0, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL flush_stage0: got %h expected %h",
                         {out_valid, out_ctrl, out_data}, {1'b0, 8'hF0, 32'hDEAD_BEEF});
    end
  endtask

  task automatic test_flush_stall();
    do_reset();
    in_valid = 1'b1;
    in_ctrl = 8'($urandom); in_data = $urandom; tick();
    in_ctrl = 8'($urandom); in_data = $urandom; tick();
    flush = 1'b1; stall = 1'b1; rand_in();
    tick();
    flush = 1'b0; stall = 1'b0;
    n_tests++;
    if ({out_valid, out_ctrl, out_data} !== exp_out()) begin
      n_fail++; $display("FAIL flush_stall_out: got %h expected %h",
                         {out_valid, out_ctrl, out_data}, exp_out());
    end
    n_tests++;
    if ({stall_cnt, flush_cnt} !== {4'h0, perf(1)}) begin
      n_fail++; $display("FAIL flush_stall_cnt: got %h expected %h",
                         {stall_cnt, flush_cnt}, {4'h0, perf(1)});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_valid = 1'b1; stall = 1'b1; tick(); stall = 1'b0;
    in_ctrl = 8'($urandom); in_data = $urandom; tick();
    in_ctrl = 8'($urandom); in_data = $urandom; tick();
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_full: out_valid got %b expected 1", out_valid);
    end
    rst_n = 1'b0; stall = 1'b1; flush = 1'b1;
    tick();
    n_tests++;
    if ({out_valid, out_ctrl, out_data, stall_cnt, flush_cnt} !== 49'h0) begin
      n_fail++; $display("FAIL mid_reset: got %h expected 0",
                         {out_valid, out_ctrl, out_data, stall_cnt, flush_cnt});
    end
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0; rand_in();
    tick();
    n_tests++;
    if ({out_valid, out_ctrl, out_data, stall_cnt, flush_cnt} !== 49'h0) begin
      n_fail++; $display("FAIL mid_residual: got %h expected 0",
                         {out_valid, out_ctrl, out_data, stall_cnt, flush_cnt});
    end
  endtask

  task automatic test_flush_after_reset();
    do_reset();
    flush = 1'b1; rand_in();
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_tests++;
    if ({out_valid, out_ctrl, out_data} !== 41'h0) begin
      n_fail++; $display("FAIL flush_post_reset: got %h expected 0", {out_valid, out_ctrl, out_data});
    end
    tick();
    n_tests++;
    if ({out_valid, out_ctrl, out_data} !== 41'h0) begin
      n_fail++; $display("FAIL flush_post_reset_s0: got %h expected 0", {out_valid, out_ctrl, out_data});
    end
  endtask

  task automatic test_saturation();
    do_reset();
    stall = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_in();
      tick();
    end
    n_tests++;
    if (stall_cnt !== perf(15)) begin
      n_fail++; $display("FAIL sat_stall: got %0d expected %0d", stall_cnt, perf(15));
    end
    tick();
    n_tests++;
    if (stall_cnt !== perf(15)) begin
      n_fail++; $display("FAIL sat_hold: got %0d expected %0d", stall_cnt, perf(15));
    end
    stall = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      flush = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 3) == 0);
      rand_in();
      tick();
      n_tests++;
      if ({out_valid, out_ctrl, out_data, stall_cnt, flush_cnt} !==
          {exp_out(), perf(m_scnt), perf(m_fcnt)}) begin
        n_fail++; $display("FAIL random[%0d]: got %h expected %h", i,
                           {out_valid, out_ctrl, out_data, stall_cnt, flush_cnt},
                           {exp_out(), perf(m_scnt), perf(m_fcnt)});
      end
    end
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_ctrl = '0; in_data = '0;
    for (int k = 0; k < ST; k++) begin
      m_valid[k] = 1'b0; m_ctrl[k] = '0; m_data[k] = '0;
    end
    m_scnt = 0; m_fcnt = 0;
    test_reset();
    test_load();
    test_stall();
    test_flush_mask();
    test_flush_stall();
    test_reset_mid();
    test_flush_after_reset();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
